// File: rtl/design_2.sv
// design_2: registered WIDTH-bit ripple-carry adder with one output register stage.
// Optional two's-complement overflow output is built when DESIGN_2_OVF_EN is defined.
module design_2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
`ifdef DESIGN_2_OVF_EN
    ,
    output logic             OVF
`endif
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    // One full-adder cell per bit; carries ripple from bit 0 upward, no lookahead.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = CIN;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    end

    always_comb begin
        sum_d  = s;
        cout_d = c[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign SUM  = sum_q;
    assign COUT = cout_q;

`ifdef DESIGN_2_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        ovf_d = c[WIDTH] ^ c[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_design_2.sv
// Directed bench for design_2: reset, directed vectors, latency and an exhaustive sweep.
module tb_design_2;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
`ifdef DESIGN_2_OVF_EN
    logic       ovf;
`endif

    int checks;
    int errors;

    design_2 #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (a),
        .B    (b),
        .CIN  (cin),
        .SUM  (sum),
        .COUT (cout)
`ifdef DESIGN_2_OVF_EN
        ,
        .OVF  (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply(input logic [3:0] va, input logic [3:0] vb, input logic vc);
        a   = va;
        b   = vb;
        cin = vc;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] exp_sum, input logic exp_cout,
                             input logic exp_ovf);
        check({tag, "_sum"}, {4'b0, sum}, {4'b0, exp_sum});
        check({tag, "_cout"}, {7'b0, cout}, {7'b0, exp_cout});
`ifdef DESIGN_2_OVF_EN
        check({tag, "_ovf"}, {7'b0, ovf}, {7'b0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("unused overflow expectation");
`endif
    endtask

    // Independent signed-overflow model: does the signed sum leave [-8, 7]?
    function automatic logic ref_ovf(input int va, input int vb, input int vc);
        int sa;
        int sb;
        int total;
        sa    = (va >= 8) ? va - 16 : va;
        sb    = (vb >= 8) ? vb - 16 : vb;
        total = sa + sb + vc;
        return (total > 7 || total < -8);
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        rst = 1'b1;
        apply(4'b1111, 4'b1111, 1'b1);
        tick();
        check_out("reset_edge1", 4'b0000, 1'b0, 1'b0);
        tick();
        check_out("reset_edge2", 4'b0000, 1'b0, 1'b0);

        rst = 1'b0;
        tick();
        check_out("after_release", 4'b1111, 1'b1, 1'b0);

        apply(4'b0000, 4'b0000, 1'b0);
        tick();
        check_out("zero", 4'b0000, 1'b0, 1'b0);

        apply(4'b1111, 4'b1111, 1'b1);
        tick();
        check_out("full_ripple", 4'b1111, 1'b1, 1'b0);

        apply(4'b1001, 4'b0000, 1'b0);
        tick();
        check_out("pass_through", 4'b1001, 1'b0, 1'b0);

        apply(4'b0010, 4'b1010, 1'b1);
        tick();
        check_out("mixed_cin", 4'b1101, 1'b0, 1'b0);

        apply(4'b0111, 4'b0001, 1'b0);
        #2;
        check_out("no_comb_path", 4'b1101, 1'b0, 1'b0);
        tick();
        check_out("back_to_back", 4'b1000, 1'b0, 1'b1);

        for (int i = 0; i < 512; i++) begin
            int va;
            int vb;
            int vc;
            int total;
            va = (i >> 5) & 15;
            vb = (i >> 1) & 15;
            vc = i & 1;
            apply(va[3:0], vb[3:0], vc[0]);
            if (i == 300) begin
                rst = 1'b1;
                tick();
                check_out("sweep_reset", 4'b0000, 1'b0, 1'b0);
                rst = 1'b0;
            end
            tick();
            total = va + vb + vc;
            check("sweep_result", {3'b0, cout, sum}, total[7:0]);
`ifdef DESIGN_2_OVF_EN
            check("sweep_ovf", {7'b0, ovf}, {7'b0, ref_ovf(va, vb, vc)});
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
